// File: rtl/button_bank.sv
// N-channel push-button conditioner: sync, integrate, hysteresis latch, press/release/long events.
// Optional auto-repeat of press_o after a long press is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_bank #(
    parameter int N_BUTTONS     = 4,
    parameter int CNT_W         = 15,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] button_i,
    output logic [N_BUTTONS-1:0] level_o,
    output logic [N_BUTTONS-1:0] press_o,
    output logic [N_BUTTONS-1:0] release_o,
    output logic [N_BUTTONS-1:0] long_o,
    output logic                 any_o
);

    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        logic              s1_q, s2_q;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              level_q, latch_d;
        logic              press_q, release_q, long_q;
        logic              rise, fall, long_hit, rep_hit;

        // Events are derived from the latch's next value so they line up with level_o.
        always_comb begin
            cnt_d = cnt_q;
            if (s2_q && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!s2_q && cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end

            latch_d = level_q;
            if (cnt_q == CNT_MAX) begin
                latch_d = 1'b1;
            end else if (cnt_q == '0) begin
                latch_d = 1'b0;
            end

            hold_d = '0;
            if (latch_d) begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            end

            rise     = latch_d & ~level_q;
            fall     = ~latch_d & level_q;
            long_hit = latch_d && (hold_q == HOLD_LAST);
        end

`ifdef BUTTON_AUTOREPEAT_EN
        logic [REP_W-1:0] rep_q, rep_d;

        // Repeat phase starts in the long_o cycle, once hold_q has saturated.
        always_comb begin
            rep_d   = '0;
            rep_hit = 1'b0;
            if (latch_d && hold_q == HOLD_MAX) begin
                rep_hit = (rep_q == REP_LAST);
                rep_d   = rep_hit ? '0 : rep_q + 1'b1;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rep_q <= '0;
            end else begin
                rep_q <= rep_d;
            end
        end
`else
        assign rep_hit = 1'b0;
`endif

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                hold_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                s1_q      <= button_i[g];
                s2_q      <= s1_q;
                cnt_q     <= cnt_d;
                level_q   <= latch_d;
                hold_q    <= hold_d;
                press_q   <= rise | rep_hit;
                release_q <= fall;
                long_q    <= long_hit;
            end
        end

        assign level_o[g]   = level_q;
        assign press_o[g]   = press_q;
        assign release_o[g] = release_q;
        assign long_o[g]    = long_q;
    end

    assign any_o = |level_o;

endmodule

// File: tb/tb_button_bank.sv
// Randomized scoreboard bench for button_bank: a cycle-level reference model queues expected
// outputs and a monitor pops and compares them every cycle; honours BUTTON_AUTOREPEAT_EN.
module tb_button_bank;

    localparam int N    = 2;
    localparam int CW   = 3;
    localparam int LONG = 20;
    localparam int REP  = 5;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic         any;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] button_i = '0;
    logic [N-1:0] level_o, press_o, release_o, long_o;
    logic         any_o;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    button_bank #(
        .N_BUTTONS(N), .CNT_W(CW), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .clock(clock), .reset_n(reset_n), .button_i(button_i),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .long_o(long_o), .any_o(any_o)
    );

    always #5 clock = ~clock;

    // Reference model state: integrator value, debounced level, cycles since rise (-1 when low).
    int cnt[N];
    bit lvl[N];
    int since[N];
    bit hist[N][$];

    always @(posedge clock) begin
        exp_t e;
        bit   s2v, new_lvl;
        e = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (!reset_n) begin
                cnt[ch] = 0;
                lvl[ch] = 0;
                since[ch] = -1;
                hist[ch].delete();
            end else begin
                hist[ch].push_back(button_i[ch]);
                if (hist[ch].size() > 3) void'(hist[ch].pop_front());
                s2v = (hist[ch].size() == 3) ? hist[ch][0] : 1'b0;
                new_lvl = (cnt[ch] == CMAX) ? 1'b1 : (cnt[ch] == 0) ? 1'b0 : lvl[ch];
                cnt[ch] = s2v ? ((cnt[ch] < CMAX) ? cnt[ch] + 1 : CMAX)
                              : ((cnt[ch] > 0) ? cnt[ch] - 1 : 0);
                since[ch] = new_lvl ? (lvl[ch] ? since[ch] + 1 : 0) : -1;
                e.press[ch] = new_lvl && !lvl[ch];
                e.rel[ch]   = !new_lvl && lvl[ch];
                e.lng[ch]   = new_lvl && (since[ch] == LONG - 1);
`ifdef BUTTON_AUTOREPEAT_EN
                if (new_lvl && since[ch] >= LONG - 1 + REP && ((since[ch] - (LONG - 1)) % REP) == 0)
                    e.press[ch] = 1'b1;
`endif
                lvl[ch] = new_lvl;
                e.level[ch] = new_lvl;
            end
        end
        e.any = |e.level;
        exp_q.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty at %0t: got 0 entries, expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("level", level_o, e.level);
            checkOutput("press", press_o, e.press);
            checkOutput("release", release_o, e.rel);
            checkOutput("long", long_o, e.lng);
            checkOutput("any", {1'b0, any_o}, {1'b0, e.any});
        end
    end

    task automatic applyStimulus(input logic [N-1:0] b, input int cycles);
        button_i = b;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic pulseReset(input int cycles);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_level", level_o, '0);
        checkOutput("reset_press", press_o, '0);
        checkOutput("reset_release", release_o, '0);
        checkOutput("reset_long", long_o, '0);
        checkOutput("reset_any", {1'b0, any_o}, '0);
        repeat (cycles) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] tgt;
        int           remain[N];
        $display("[TB] starting button_bank bench");
        @(negedge clock);
        pulseReset(3);
        applyStimulus(2'b00, 50);

        // Directed: clean press/release, bounce burst, long press, short press.
        applyStimulus(2'b01, 20);
        applyStimulus(2'b00, 15);
        foreach (remain[i]) remain[i] = 0;
        begin
            logic [7:0] bounce;
            bounce = 8'b00101101;
            for (int i = 0; i < 8; i++) applyStimulus({1'b0, bounce[i]}, 1);
        end
        applyStimulus(2'b00, 15);
        applyStimulus(2'b10, 40);
        applyStimulus(2'b00, 15);
        applyStimulus(2'b10, 15);
        applyStimulus(2'b00, 15);

        // Long hold on ch0 (auto-repeat window when enabled), async reset mid-hold.
        applyStimulus(2'b01, 45);
        pulseReset(2);
        applyStimulus(2'b01, 15);
        applyStimulus(2'b00, 15);

        // Randomized mix of bounces, short and long presses, plus occasional resets.
        tgt = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (remain[ch] == 0) begin
                    tgt[ch] = ~tgt[ch];
                    remain[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8)
                                                             : $urandom_range(12, 50);
                end
                remain[ch]--;
            end
            if ($urandom_range(0, 999) == 0) begin
                button_i = tgt;
                pulseReset($urandom_range(1, 3));
            end else begin
                applyStimulus(tgt, 1);
            end
        end

        applyStimulus(2'b00, 20);
        @(posedge clock);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
Multi-channel successor to the single-button debouncer: N independent button inputs, each with a synchronizer, a saturating integrating counter and a hysteresis latch. Each channel adds press/release pulses, long-press detection and an "any button held" summary. The block sits between the board push-buttons and the VGA mode/control logic. Consumers get clean one-cycle events instead of a bare level.

Parameters:
N_BUTTONS, 4, number of independent channels.
CNT_W, 15, integrator width; the debounce threshold is all-ones (2^CNT_W-1).
LONG_CYCLES, 25000000, cycles level_o must stay high before long_o fires; must be >= 2.
REPEAT_CYCLES, 5000000, auto-repeat period, used only with the optional feature; must be >= 2.

Ports:
clock  in  1  single system clock; all logic is rising-edge.
reset_n  in  1  asynchronous, active-low reset.
button_i  in  N_BUTTONS  raw asynchronous button levels, active-high.
level_o  out  N_BUTTONS  debounced level per channel.
press_o  out  N_BUTTONS  one-cycle pulse on a debounced rising edge (and on auto-repeat, if enabled).
release_o  out  N_BUTTONS  one-cycle pulse on a debounced falling edge.
long_o  out  N_BUTTONS  one-cycle pulse when a press has lasted LONG_CYCLES.
any_o  out  1  OR of level_o.

Behaviour:
- Reset:
  - Clock and reset ports: a single clock (clock); reset_n is asynchronous, active-low.
  - Asserting reset_n=0 immediately clears all registers: synchronizers, counters, latches, hold counters and all outputs to 0.
  - No pulses are generated on deassertion.
  - A button held through reset is debounced from counter 0, so press_o fires 2^CNT_W+2 edges after release of reset.
- Per channel, fully independent:
  - Synchronizer: 2-flop chain, s1 then s2.
  - Integrator, CNT_W bits:
    - s2=1 and not all-ones: +1.
    - s2=0 and nonzero: -1.
    - Otherwise hold. It saturates and never wraps.
  - Latch:
    - Set when the counter is all-ones.
    - Cleared when the counter is zero.
    - Otherwise hold (hysteresis). level_o is the latch output.
  - Latency: first edge sampling a new steady level is edge 1. level_o changes after edge 2^CNT_W+2 (CNT_W=3 gives 10).
  - Glitches shorter than 2^CNT_W-1 sampled cycles never toggle level_o.
- Event pulses (registered):
  - press_o is high for exactly the first cycle level_o is 1.
  - release_o is high for exactly the first cycle level_o is 0 after having been 1.
  - They are never high together on the same channel.
- Long press:
  - hold_cnt, width clog2(LONG_CYCLES+1), is 0 while level_o=0.
  - While level_o=1 it counts cycles since the rise, saturating at LONG_CYCLES.
  - If level_o first rises in cycle t0, long_o pulses in cycle t0+LONG_CYCLES-1, provided level_o is still 1.
  - At most one long_o per press. Release before that cycle gives no long_o.
- any_o: combinational OR of the level_o registers.
- Simultaneous events on different channels are all reported in the same cycle; there is no arbitration.

Optional Feature:
Macro BUTTON_AUTOREPEAT_EN.
- Defined: after long_o fires for a channel, press_o on that channel additionally pulses every REPEAT_CYCLES cycles (first repeat REPEAT_CYCLES cycles after long_o) while level_o stays 1. Repeats stop on release. The repeat counter clears on release and on reset.
- Undefined: no repeat logic is synthesized; press_o pulses only on a debounced rising edge.

Test Plan:
1. CNT_W=3, N=2. Hold reset_n=0 for 3 cycles, then release with inputs at 0 -> all outputs 0; no pulses for 50 cycles.
2. Drive button_i[0]=1 steadily -> level_o[0] rises after edge 10; press_o[0] high that single cycle; any_o=1; channel 1 unchanged.
3. Bounce ch0 1,0,1,1,0,1,0,0 and then steady 0 from idle -> level_o[0] stays 0; no press_o or release_o.
4. From a debounced high, drive 0 -> level_o[0] falls after edge 10; release_o[0] is a one-cycle pulse; press_o=0 that cycle.
5. LONG_CYCLES=20, hold ch1 high -> long_o[1] exactly once, 19 cycles after press_o[1]. Release earlier at 15 cycles -> no long_o.
6. BUTTON_AUTOREPEAT_EN, LONG_CYCLES=20, REPEAT_CYCLES=5, hold ch0 -> press_o at t0, long_o at t0+19, press_o at t0+24, t0+29 and onward. Async reset_n=0 mid-hold -> all outputs 0 at once; repeats stop.
